// File: rtl/avl_sdram_responder_if.sv
// Avalon-MM bus bundle for the SDRAM responder model: word-addressed 16-bit
// requests from the initiator plus the responder's stall and read-return signals.
interface avl_sdram_responder_if;
    logic [24:0] address;
    logic [1:0]  byteenable_n;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        readdatavalid;
    logic        waitrequest;

    modport master (
        output address, byteenable_n, chipselect, read_n, write_n, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, byteenable_n, chipselect, read_n, write_n, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/avl_sdram_responder.sv
// On-chip-memory stand-in for the SDRAM controller port: init stall, periodic
// refresh stalls and fixed-latency pipelined reads with bounded outstanding count.
module avl_sdram_responder #(
    parameter int MEM_AW         = 10,
    parameter int READ_LATENCY   = 2,
    parameter int MAX_PENDING    = 2,
    parameter int INIT_CYCLES    = 16,
    parameter int REFRESH_PERIOD = 64,
    parameter int REFRESH_CYCLES = 4
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset,
    avl_sdram_responder_if.slave   sdram,
    output logic                   proto_err
);
    localparam logic [1:0] ST_INIT    = 2'd0;
    localparam logic [1:0] ST_READY   = 2'd1;
    localparam logic [1:0] ST_REFRESH = 2'd2;

    localparam int IW = $clog2(INIT_CYCLES + 1);
    localparam int RW = $clog2(REFRESH_PERIOD + 1);
    localparam int OW = $clog2(MAX_PENDING + 1);

    localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);
    localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_PERIOD - 1);
    localparam logic [RW-1:0] RFSH_LAST = RW'(REFRESH_CYCLES - 1);
    localparam logic [OW-1:0] PEND_MAX  = OW'(MAX_PENDING);

    logic [1:0]              state;
    logic [IW-1:0]           init_cnt;
    logic [RW-1:0]           ref_cnt;
    logic [OW-1:0]           outstanding;
    logic [15:0]             mem [2**MEM_AW];
    logic [READ_LATENCY-1:0] vld_p;
    logic [15:0]             dat_p [READ_LATENCY];

    logic              stall;
    logic              accept;
    logic              wr_acc;
    logic              rd_acc;
    logic              rdv;
    logic [MEM_AW-1:0] idx;
    logic              unused_addr_hi;

    // Stall depends only on registered state so the initiator sees a clean signal.
    assign stall  = (state != ST_READY) || (outstanding == PEND_MAX);
    assign accept = sdram.chipselect && (!sdram.read_n || !sdram.write_n)
                    && !stall && !reset_reset;
    // A combined read+write request is executed as a write only.
    assign wr_acc = accept && !sdram.write_n;
    assign rd_acc = accept && sdram.write_n;
    assign rdv    = vld_p[READ_LATENCY-1];
    assign idx    = sdram.address[MEM_AW-1:0];

    assign unused_addr_hi = ^sdram.address[24:MEM_AW];

    assign sdram.waitrequest   = stall;
    assign sdram.readdatavalid = rdv;
    assign sdram.readdata      = rdv ? dat_p[READ_LATENCY-1] : 16'h0000;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            ref_cnt  <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (init_cnt == INIT_LAST) begin
                        state   <= ST_READY;
                        ref_cnt <= '0;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                ST_READY: begin
                    if (ref_cnt == REF_LAST) begin
                        state   <= ST_REFRESH;
                        ref_cnt <= '0;
                    end else begin
                        ref_cnt <= ref_cnt + 1'b1;
                    end
                end
                ST_REFRESH: begin
                    if (ref_cnt == RFSH_LAST) begin
                        state   <= ST_READY;
                        ref_cnt <= '0;
                    end else begin
                        ref_cnt <= ref_cnt + 1'b1;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            outstanding <= '0;
            proto_err   <= 1'b0;
        end else begin
            case ({rd_acc, rdv})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            if (accept && !sdram.read_n && !sdram.write_n)
                proto_err <= 1'b1;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (wr_acc) begin
            if (!sdram.byteenable_n[0]) mem[idx][7:0]  <= sdram.writedata[7:0];
            if (!sdram.byteenable_n[1]) mem[idx][15:8] <= sdram.writedata[15:8];
        end
    end

    // Read stage boundary: valid shift is reset, data shift is not (output is gated).
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= rd_acc;
            for (int i = 1; i < READ_LATENCY; i++)
                vld_p[i] <= vld_p[i-1];
        end
    end

    always_ff @(posedge clk_clk) begin
        if (rd_acc)
            dat_p[0] <= mem[idx];
        for (int i = 1; i < READ_LATENCY; i++)
            dat_p[i] <= dat_p[i-1];
    end
endmodule

// File: tb/tb_avl_sdram_responder.sv
// Randomized bench for avl_sdram_responder against a timeline/queue reference model.
module tb_avl_sdram_responder;
    localparam int MEM_AW = 10;
    localparam int RL     = 2;
    localparam int MAXP   = 2;
    localparam int INITC  = 16;
    localparam int PER    = 64;
    localparam int RC     = 4;

    typedef struct {
        int          a;
        logic [15:0] d;
    } rd_t;

    logic clk = 1'b0;
    logic rst;
    logic proto_err;
    int   cyc = 0;

    avl_sdram_responder_if sdram_bus ();

    avl_sdram_responder #(
        .MEM_AW(MEM_AW), .READ_LATENCY(RL), .MAX_PENDING(MAXP),
        .INIT_CYCLES(INITC), .REFRESH_PERIOD(PER), .REFRESH_CYCLES(RC)
    ) dut (
        .clk_clk(clk),
        .reset_reset(rst),
        .sdram(sdram_bus),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] ref_mem [2**MEM_AW];
    rd_t         pq [$];
    logic [15:0] rd_log [$];
    logic        m_proto  = 1'b0;
    bit          model_on = 1'b0;
    int          init_end = 0;
    int          last_c   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // READY windows repeat every PER+RC cycles once the init stall is over.
    function automatic bit ready_at(input int c);
        if (c < init_end) return 1'b0;
        return ((c - init_end) % (PER + RC)) < PER;
    endfunction

    task automatic step(input logic r, input logic cs, input logic rn, input logic wn,
                        input logic [24:0] ad, input logic [1:0] be, input logic [15:0] wd,
                        output logic acc, output logic w);
        int          c;
        logic        ew;
        logic        erdv;
        logic [15:0] ed;
        @(negedge clk);
        c      = cyc;
        last_c = c;
        ew     = 1'b1;
        w      = sdram_bus.waitrequest;
        if (model_on) begin
            ew   = !ready_at(c) || (pq.size() == MAXP);
            erdv = (pq.size() > 0) && (pq[0].a + RL - 1 == c);
            ed   = erdv ? pq[0].d : 16'h0000;
            check_eq("waitrequest", {31'b0, sdram_bus.waitrequest}, {31'b0, ew});
            check_eq("readdatavalid", {31'b0, sdram_bus.readdatavalid}, {31'b0, erdv});
            check_eq("readdata", {16'b0, sdram_bus.readdata}, {16'b0, ed});
            check_eq("proto_err", {31'b0, proto_err}, {31'b0, m_proto});
            if (sdram_bus.readdatavalid === 1'b1) rd_log.push_back(sdram_bus.readdata);
            if (erdv) void'(pq.pop_front());
        end
        rst                    = r;
        sdram_bus.chipselect   = r ? 1'b0 : cs;
        sdram_bus.read_n       = rn;
        sdram_bus.write_n      = wn;
        sdram_bus.address      = ad;
        sdram_bus.byteenable_n = be;
        sdram_bus.writedata    = wd;
        acc = 1'b0;
        if (r) begin
            pq.delete();
            m_proto  = 1'b0;
            init_end = c + 1 + INITC;
            model_on = 1'b1;
        end else if (model_on && cs && (!rn || !wn) && !ew) begin
            acc = 1'b1;
            if (!wn) begin
                if (!be[0]) ref_mem[ad[MEM_AW-1:0]][7:0]  = wd[7:0];
                if (!be[1]) ref_mem[ad[MEM_AW-1:0]][15:8] = wd[15:8];
                if (!rn) m_proto = 1'b1;
            end else begin
                pq.push_back('{a: c + 1, d: ref_mem[ad[MEM_AW-1:0]]});
            end
        end
    endtask

    task automatic idle(input int n);
        logic acc, w;
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 1'($urandom), 1'($urandom), 25'($urandom), 2'($urandom),
                 16'($urandom), acc, w);
    endtask

    task automatic do_reset();
        logic acc, w;
        step(1'b1, 1'b0, 1'b1, 1'b1, 25'h0, 2'b11, 16'h0, acc, w);
    endtask

    task automatic xfer(input logic rn, input logic wn, input logic [24:0] ad,
                        input logic [1:0] be, input logic [15:0] wd, output int nwait);
        logic acc, w;
        acc   = 1'b0;
        nwait = 0;
        for (int n = 0; n < 200 && !acc; n++) begin
            step(1'b0, 1'b1, rn, wn, ad, be, wd, acc, w);
            if (w) nwait++;
        end
        check_eq("xfer_accept", {31'b0, acc}, 32'd1);
    endtask

    function automatic logic [31:0] log_at(input int i);
        return (rd_log.size() > i) ? {16'b0, rd_log[i]} : 32'hDEAD_BEEF;
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int nw;
        int tot;
        rst = 1'b1;
        sdram_bus.chipselect   = 1'b0;
        sdram_bus.read_n       = 1'b1;
        sdram_bus.write_n      = 1'b1;
        sdram_bus.address      = '0;
        sdram_bus.byteenable_n = 2'b11;
        sdram_bus.writedata    = '0;
        for (int i = 0; i < 2**MEM_AW; i++) ref_mem[i] = 16'h0000;
        do_reset();
        do_reset();

        // Init stall with a held write.
        xfer(1'b1, 1'b0, 25'h0, 2'b00, 16'h5A5A, nw);
        check_eq("init_stall", nw, INITC);
        for (int i = 0; i < 2**MEM_AW; i++)
            xfer(1'b1, 1'b0, 25'(i), 2'b00, 16'($urandom), nw);

        // Write then read, with aliased high address bits.
        rd_log.delete();
        xfer(1'b1, 1'b0, 25'h000100, 2'b00, 16'h0007, nw);
        xfer(1'b0, 1'b1, 25'h000500, 2'b00, 16'h0000, nw);
        idle(4);
        check_eq("rd_alias_cnt", rd_log.size(), 1);
        check_eq("rd_alias_data", log_at(0), 32'h0007);

        // Byte lanes.
        rd_log.delete();
        xfer(1'b1, 1'b0, 25'h000020, 2'b00, 16'hFFFF, nw);
        xfer(1'b1, 1'b0, 25'h000020, 2'b10, 16'h1234, nw);
        xfer(1'b0, 1'b1, 25'h000020, 2'b00, 16'h0000, nw);
        xfer(1'b1, 1'b0, 25'h000020, 2'b11, 16'h0000, nw);
        xfer(1'b0, 1'b1, 25'h000020, 2'b00, 16'h0000, nw);
        idle(4);
        check_eq("be_lo_data", log_at(0), 32'hFF34);
        check_eq("be_none_data", log_at(1), 32'hFF34);

        // Back-to-back reads limited by MAX_PENDING.
        for (int i = 0; i < 4; i++) xfer(1'b1, 1'b0, 25'(i), 2'b00, 16'hA000 + 16'(i), nw);
        rd_log.delete();
        tot = 0;
        for (int i = 0; i < 4; i++) begin
            xfer(1'b0, 1'b1, 25'(i), 2'b00, 16'h0, nw);
            tot += nw;
        end
        idle(6);
        check_eq("b2b_stall_seen", {31'b0, tot >= 1}, 32'd1);
        check_eq("b2b_cnt", rd_log.size(), 4);
        for (int i = 0; i < 4; i++) check_eq("b2b_order", log_at(i), 32'hA000 + i);

        // Read on the last READY cycle before a refresh.
        for (int n = 0; n < 300; n++) begin
            if (pq.size() == 0 && ready_at(last_c + 1) &&
                ((last_c + 1 - init_end) % (PER + RC)) == PER - 1) break;
            idle(1);
        end
        rd_log.delete();
        xfer(1'b0, 1'b1, 25'h3, 2'b00, 16'h0, nw);
        check_eq("last_ready_nowait", nw, 0);
        xfer(1'b0, 1'b1, 25'h2, 2'b00, 16'h0, nw);
        check_eq("refresh_stall", nw, RC);
        idle(4);
        check_eq("refresh_rd_cnt", rd_log.size(), 2);
        check_eq("refresh_rd0", log_at(0), 32'hA003);

        // Combined read+write, then reset with reads in flight.
        rd_log.delete();
        xfer(1'b0, 1'b0, 25'h000010, 2'b00, 16'hABCD, nw);
        idle(4);
        check_eq("proto_sticky", {31'b0, proto_err}, 32'd1);
        check_eq("proto_no_rdv", rd_log.size(), 0);
        xfer(1'b0, 1'b1, 25'h000010, 2'b00, 16'h0, nw);
        idle(4);
        check_eq("proto_rd_data", log_at(0), 32'hABCD);
        xfer(1'b0, 1'b1, 25'h1, 2'b00, 16'h0, nw);
        xfer(1'b0, 1'b1, 25'h2, 2'b00, 16'h0, nw);
        do_reset();
        rd_log.delete();
        idle(6);
        check_eq("rst_drop_rdv", rd_log.size(), 0);
        check_eq("rst_proto_clr", {31'b0, proto_err}, 32'd0);

        // Random traffic with occasional resets.
        for (int k = 0; k < 700; k++) begin
            int          op;
            logic [24:0] ad;
            op = $urandom_range(0, 15);
            ad = {15'($urandom), 10'($urandom_range(0, 31))};
            if (k % 175 == 174) do_reset();
            else if (op < 4) idle(1);
            else if (op < 9) xfer(1'b0, 1'b1, ad, 2'($urandom), 16'($urandom), nw);
            else if (op < 15) xfer(1'b1, 1'b0, ad, 2'($urandom), 16'($urandom), nw);
            else xfer(1'b0, 1'b0, ad, 2'($urandom), 16'($urandom), nw);
        end
        idle(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/avl_sdram_responder.md
Name: avl_sdram_responder

Overview:
- Avalon-MM responder (slave) model of the SDRAM controller's `sdram_*` port.
- Accepts the same word-addressed 16-bit read/write transactions that our initiator FSMs issue, backed by on-chip memory.
- Emulates controller timing: power-up init stall, periodic refresh stalls, fixed-latency pipelined reads.
- Used as the SDRAM stand-in for bring-up and simulation of initiator logic without the physical chip.

Parameters:
- MEM_AW, 10, number of address LSBs decoded; depth = 2**MEM_AW 16-bit words.
- READ_LATENCY, 2, cycles from read acceptance to readdatavalid (legal 1..8).
- MAX_PENDING, 2, max outstanding reads before waitrequest (1..READ_LATENCY).
- INIT_CYCLES, 16, waitrequest-high cycles after reset release (>=1).
- REFRESH_PERIOD, 64, READY cycles between refresh stalls (> REFRESH_CYCLES).
- REFRESH_CYCLES, 4, length of each refresh stall (>=1).

Ports:
- clk_clk  in  1  sole clock; all logic on rising edge.
- reset_reset  in  1  synchronous, active-high reset.
- sdram_address  in  25  word address; bits above MEM_AW-1 ignored (aliased).
- sdram_byteenable_n  in  2  active-low byte enables; bit0 = [7:0], bit1 = [15:8].
- sdram_chipselect  in  1  transaction qualifier.
- sdram_read_n  in  1  active-low read request.
- sdram_write_n  in  1  active-low write request.
- sdram_writedata  in  16  write data.
- sdram_readdata  out  16  read data; 0 whenever readdatavalid=0.
- sdram_readdatavalid  out  1  one-cycle strobe per accepted read.
- sdram_waitrequest  out  1  stall; a function of registered state only.
- proto_err  out  1  sticky flag: read and write requested in the same cycle.

Behaviour:
- Reset: one clock with reset_reset=1 and synchronous reset takes effect.
  - Outputs: waitrequest=1, readdatavalid=0, readdata=0, proto_err=0.
  - State: state=INIT, init/refresh counters=0, read pipeline flushed, outstanding=0.
  - Memory contents are not cleared.
- Reset mid-operation: in-flight reads are dropped; no readdatavalid after the reset edge.
- Accept condition: chipselect & (!read_n | !write_n) & !waitrequest, sampled at the rising edge.
- chipselect=0 ignores read_n/write_n.
- Write: at the accept edge, mem[addr[MEM_AW-1:0]] is updated only in byte lanes whose byteenable_n bit is 0. byteenable_n=2'b11 is an accepted write that changes nothing.
- Read: memory is sampled at the accept edge.
  - A write accepted in an earlier cycle is visible.
  - Data is delivered through a READ_LATENCY-deep valid/data shift pipeline.
  - readdatavalid=1 exactly READ_LATENCY cycles after the accept edge.
  - Back-to-back reads return in order, one per cycle.
- Simultaneous read_n=0 and write_n=0 when accepted: treated as a write only, no read is issued, proto_err set to 1 until reset.
- outstanding counter:
  - +1 on read accept, -1 on readdatavalid; both in one cycle leaves it unchanged.
  - Never exceeds MAX_PENDING.
- State machine:
  - INIT: waitrequest=1. Counts INIT_CYCLES, then goes to READY and clears the refresh counter.
  - READY: waitrequest = (outstanding_next_cycle_registered == MAX_PENDING), i.e. registered full flag. Refresh counter increments each cycle; at REFRESH_PERIOD-1, next state = REFRESH.
  - REFRESH: waitrequest=1 for REFRESH_CYCLES cycles, then READY with the refresh counter cleared.
- Refresh scheduling and in-flight reads:
  - Refresh entry is not deferred by a pending request; the initiator holds the request until waitrequest drops.
  - Reads already in the pipeline keep draining during REFRESH; readdatavalid is unaffected by stalls.
- Initiator holds its request stable while waitrequest=1; the responder performs no action for a held request until acceptance.
- Refresh counter wraps only via the REFRESH state.
- Address LSB aliasing: 25'h000100 and 25'h000500 map to the same word when MEM_AW=10.

Test Plan:
- Reset release, chipselect=1, write_n=0 held -> waitrequest=1 for exactly 16 cycles, then write accepted on cycle 17.
- Write 16'h0007 to 25'h000100, then read 25'h000100 next cycle -> readdatavalid 2 cycles after read accept, readdata=16'h0007.
- Write 16'hFFFF then 16'h1234 with byteenable_n=2'b10 to 25'h000020, read -> 16'hFF34. Then write with byteenable_n=2'b11, read -> still 16'hFF34.
- Four back-to-back reads of 25'h0..25'h3, MAX_PENDING=2 -> waitrequest rises when 2 outstanding. All four readdatavalid strobes arrive in address order, no loss or duplication.
- Issue a read on the last READY cycle before refresh -> readdatavalid still arrives 2 cycles later during REFRESH; waitrequest=1 for 4 cycles; a next read is accepted on the first READY cycle.
- read_n=0 and write_n=0 together with data 16'hABCD at 25'h000010 -> proto_err=1 sticky, no readdatavalid, later read returns 16'hABCD. Assert reset_reset with 2 reads in flight -> no readdatavalid afterwards, proto_err=0.
